// File: rtl/cdb_arbiter_if.sv
// Common Data Bus arbitration interface: functional-unit requests in, granted broadcast out.
// The master side belongs to the producers and bus control; the slave side belongs to the arbiter.
interface cdb_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) ();

  logic [N_REQ-1:0]        req;
  logic [N_REQ*TAG_W-1:0]  req_tag;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        gnt;
  logic                    cdb_hold;
  logic                    flush;
  logic                    cdb_valid;
  logic [TAG_W-1:0]        cdb_tag;
  logic [DATA_W-1:0]       cdb_data;
  logic                    err_tag0;

  modport master (
    output req,
    output req_tag,
    output req_data,
    output cdb_hold,
    output flush,
    input  gnt,
    input  cdb_valid,
    input  cdb_tag,
    input  cdb_data,
    input  err_tag0
  );

  modport slave (
    input  req,
    input  req_tag,
    input  req_data,
    input  cdb_hold,
    input  flush,
    output gnt,
    output cdb_valid,
    output cdb_tag,
    output cdb_data,
    output err_tag0
  );

endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single CDB broadcast port among result producers.
// Grant is combinational; the granted tag/data appear on the registered bus one cycle later.
module cdb_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned TAG_W  = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  cdb_arbiter_if.slave     bus_io
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic              cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic              err_tag0_q, err_tag0_d;

  logic [TAG_W-1:0]  tag_arr  [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];

  logic              arb_en;
  logic              gnt_any;
  logic [PtrW-1:0]   gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic [PtrW:0]     search_idx;
  logic [TAG_W-1:0]  sel_tag;
  logic [DATA_W-1:0] sel_data;
  logic [PtrW-1:0]   ptr_after_gnt;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign tag_arr[k]  = bus_io.req_tag[k*TAG_W +: TAG_W];
    assign data_arr[k] = bus_io.req_data[k*DATA_W +: DATA_W];
  end

  // Search starts at ptr_q and wraps; the first requester found wins.
  always_comb begin
    gnt        = '0;
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    search_idx = '0;
    arb_en     = rst_n & ~bus_io.flush & ~bus_io.cdb_hold;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      search_idx = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (search_idx >= (PtrW+1)'(N_REQ)) begin
        search_idx = search_idx - (PtrW+1)'(N_REQ);
      end
      if (arb_en && !gnt_any && bus_io.req[search_idx[PtrW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = search_idx[PtrW-1:0];
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  assign sel_tag       = tag_arr[gnt_idx];
  assign sel_data      = data_arr[gnt_idx];
  assign ptr_after_gnt = (gnt_idx == PtrW'(N_REQ - 1)) ? '0 : gnt_idx + PtrW'(1);

  // flush beats hold, hold beats requests; a tag-0 grant is consumed but never broadcast.
  always_comb begin
    ptr_d       = ptr_q;
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    err_tag0_d  = err_tag0_q;
    if (bus_io.flush) begin
      cdb_valid_d = 1'b0;
    end else if (bus_io.cdb_hold) begin
      cdb_valid_d = cdb_valid_q;
    end else if (gnt_any) begin
      ptr_d = ptr_after_gnt;
      if (sel_tag != '0) begin
        cdb_valid_d = 1'b1;
        cdb_tag_d   = sel_tag;
        cdb_data_d  = sel_data;
      end else begin
        cdb_valid_d = 1'b0;
        err_tag0_d  = 1'b1;
      end
    end else begin
      cdb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      err_tag0_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      err_tag0_q  <= err_tag0_d;
    end
  end

  assign bus_io.gnt       = gnt;
  assign bus_io.cdb_valid = cdb_valid_q;
  assign bus_io.cdb_tag   = cdb_tag_q;
  assign bus_io.cdb_data  = cdb_data_q;
  assign bus_io.err_tag0  = err_tag0_q;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
    else $error("cdb_arbiter: grant not one-hot");

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter with hand-computed expectations.
module tb_cdb_arbiter;

  localparam int unsigned NReq  = 4;
  localparam int unsigned TagW  = 5;
  localparam int unsigned DataW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cdb_arbiter_if #(.N_REQ(NReq), .TAG_W(TagW), .DATA_W(DataW)) bus ();

  cdb_arbiter #(.N_REQ(NReq), .TAG_W(TagW), .DATA_W(DataW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  logic [TagW-1:0]  tag_v  [NReq];
  logic [DataW-1:0] data_v [NReq];

  for (genvar k = 0; k < NReq; k++) begin : g_pack
    assign bus.req_tag[k*TagW +: TagW]    = tag_v[k];
    assign bus.req_data[k*DataW +: DataW] = data_v[k];
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Producer protocol: a pending request may only disappear after being granted.
  logic [NReq-1:0] pend_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else begin
      assert ((pend_q & ~bus.req) == '0)
        else $error("protocol: req dropped without grant");
      pend_q <= bus.req & ~bus.gnt;
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_unit(input int k, input logic [TagW-1:0] t, input logic [DataW-1:0] d);
    tag_v[k]  = t;
    data_v[k] = d;
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.cdb_hold = 1'b0;
    bus.flush    = 1'b0;
    for (int k = 0; k < NReq; k++) set_unit(k, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cdb_hold = 1'b0;
    bus.flush    = 1'b0;
    for (int k = 0; k < NReq; k++) set_unit(k, TagW'(k + 1), DataW'(k));
    bus.req = 4'b1111;
    @(negedge clk);
    #1;
    check_eq("rst_gnt", 64'(bus.gnt), 64'h0);
    check_eq("rst_valid", 64'(bus.cdb_valid), 64'h0);
    check_eq("rst_tag", 64'(bus.cdb_tag), 64'h0);
    check_eq("rst_data", 64'(bus.cdb_data), 64'h0);
    check_eq("rst_err", 64'(bus.err_tag0), 64'h0);
    do_reset();

    // Single requester, then idle, then pointer sits at 3
    set_unit(2, 5'd7, 32'hDEAD_BEEF);
    bus.req = 4'b0100;
    #1 check_eq("single_gnt", 64'(bus.gnt), 64'h4);
    step();
    bus.req = 4'b0000;
    #1;
    check_eq("single_valid", 64'(bus.cdb_valid), 64'h1);
    check_eq("single_tag", 64'(bus.cdb_tag), 64'h7);
    check_eq("single_data", 64'(bus.cdb_data), 64'hDEAD_BEEF);
    step();
    #1;
    check_eq("idle_valid", 64'(bus.cdb_valid), 64'h0);
    check_eq("idle_tag_kept", 64'(bus.cdb_tag), 64'h7);
    for (int k = 0; k < NReq; k++) set_unit(k, TagW'(k + 1), DataW'(k));
    bus.req = 4'b1111;
    #1 check_eq("ptr3_gnt", 64'(bus.gnt), 64'h8);
    do_reset();

    // All four requesting: 0,1,2,3,0
    for (int k = 0; k < NReq; k++) set_unit(k, TagW'(k + 1), 32'h100 + DataW'(k));
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1 check_eq("rr_gnt", 64'(bus.gnt), 64'(1) << (i % 4));
      step();
      #1;
      check_eq("rr_valid", 64'(bus.cdb_valid), 64'h1);
      check_eq("rr_tag", 64'(bus.cdb_tag), 64'((i % 4) + 1));
      check_eq("rr_data", 64'(bus.cdb_data), 64'(32'h100 + (i % 4)));
    end
    do_reset();

    // Move ptr to 2, then wrap-around order 3,0,1
    set_unit(1, 5'd2, 32'h11);
    bus.req = 4'b0010;
    #1 check_eq("wrap_pre_gnt", 64'(bus.gnt), 64'h2);
    step();
    set_unit(0, 5'd1, 32'h10);
    set_unit(3, 5'd4, 32'h13);
    bus.req = 4'b1011;
    #1 check_eq("wrap_gnt3", 64'(bus.gnt), 64'h8);
    step();
    bus.req = 4'b0011;
    #1;
    check_eq("wrap_tag4", 64'(bus.cdb_tag), 64'h4);
    check_eq("wrap_gnt0", 64'(bus.gnt), 64'h1);
    step();
    bus.req = 4'b0010;
    #1 check_eq("wrap_gnt1", 64'(bus.gnt), 64'h2);
    step();
    bus.req = 4'b0000;
    #1 check_eq("wrap_tag2", 64'(bus.cdb_tag), 64'h2);
    do_reset();

    // Hold keeps the tag-9 broadcast and blocks unit 0's next result
    set_unit(0, 5'd9, 32'h99);
    bus.req = 4'b0001;
    #1 check_eq("hold_pre_gnt", 64'(bus.gnt), 64'h1);
    step();
    set_unit(0, 5'd10, 32'hAA);
    bus.cdb_hold = 1'b1;
    repeat (3) begin
      #1;
      check_eq("hold_gnt", 64'(bus.gnt), 64'h0);
      check_eq("hold_valid", 64'(bus.cdb_valid), 64'h1);
      check_eq("hold_tag", 64'(bus.cdb_tag), 64'h9);
      step();
    end
    bus.cdb_hold = 1'b0;
    #1;
    check_eq("hold_tag_after", 64'(bus.cdb_tag), 64'h9);
    check_eq("hold_release_gnt", 64'(bus.gnt), 64'h1);
    step();
    bus.req = 4'b0000;
    #1;
    check_eq("hold_next_valid", 64'(bus.cdb_valid), 64'h1);
    check_eq("hold_next_tag", 64'(bus.cdb_tag), 64'hA);
    check_eq("hold_next_data", 64'(bus.cdb_data), 64'hAA);
    do_reset();

    // Flush with hold and full request: no grant, bus cleared, ptr kept at 1
    set_unit(0, 5'd5, 32'h55);
    bus.req = 4'b0001;
    step();
    for (int k = 1; k < NReq; k++) set_unit(k, TagW'(k + 1), DataW'(k));
    bus.req      = 4'b1111;
    bus.cdb_hold = 1'b1;
    bus.flush    = 1'b1;
    #1;
    check_eq("flush_pre_valid", 64'(bus.cdb_valid), 64'h1);
    check_eq("flush_gnt", 64'(bus.gnt), 64'h0);
    step();
    bus.flush    = 1'b0;
    bus.cdb_hold = 1'b0;
    #1;
    check_eq("flush_valid", 64'(bus.cdb_valid), 64'h0);
    check_eq("flush_tag_kept", 64'(bus.cdb_tag), 64'h5);
    check_eq("flush_ptr_gnt", 64'(bus.gnt), 64'h2);
    do_reset();

    // Tag-0 request: consumed, not broadcast, sticky error; async reset clears all
    set_unit(0, 5'd3, 32'h33);
    bus.req = 4'b0001;
    step();
    set_unit(1, 5'd0, 32'h44);
    bus.req = 4'b0010;
    #1 check_eq("tag0_gnt", 64'(bus.gnt), 64'h2);
    step();
    bus.req = 4'b0000;
    #1;
    check_eq("tag0_valid", 64'(bus.cdb_valid), 64'h0);
    check_eq("tag0_tag_kept", 64'(bus.cdb_tag), 64'h3);
    check_eq("tag0_data_kept", 64'(bus.cdb_data), 64'h33);
    check_eq("tag0_err", 64'(bus.err_tag0), 64'h1);
    repeat (3) step();
    #1 check_eq("tag0_err_sticky", 64'(bus.err_tag0), 64'h1);
    set_unit(0, 5'd6, 32'h66);
    bus.req = 4'b0001;
    step();
    #1;
    check_eq("pre_rst_valid", 64'(bus.cdb_valid), 64'h1);
    check_eq("pre_rst_tag", 64'(bus.cdb_tag), 64'h6);
    check_eq("pre_rst_err", 64'(bus.err_tag0), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(bus.cdb_valid), 64'h0);
    check_eq("async_rst_tag", 64'(bus.cdb_tag), 64'h0);
    check_eq("async_rst_data", 64'(bus.cdb_data), 64'h0);
    check_eq("async_rst_err", 64'(bus.err_tag0), 64'h0);
    check_eq("async_rst_gnt", 64'(bus.gnt), 64'h0);
    bus.req = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
